reg_file_ctx: RTL and testbench

Parametrised, context-banked successor to the processor register file, clocked by a single clock. It holds NUM_CTX private register banks plus one bank of global registers shared across contexts. Reads are combinational with write-to-read bypass. A context-switch port lets the OS layer change the active bank in one cycle, and a sequential clear engine zeroes a chosen bank's private registers in the background. It sits in the processor datapath in place of the single-bank file and keeps the same 3-read / 1-write shape.

---
 rtl/reg_file_ctx_pkg.sv | 17 +
 rtl/reg_file_ctx_if.sv | 40 ++++
 rtl/reg_file_clear_fsm.sv | 77 +++++++
 rtl/reg_file_ctx.sv | 86 ++++++++
 tb/tb_reg_file_ctx.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_ctx_pkg.sv
// Shared definitions for the context-banked register file: default sizes and
// the encoding of the background clear engine's states.
package reg_file_ctx_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_NUM_CTX     = 4;
  localparam int DEF_CTX_WIDTH   = 2;
  localparam int DEF_SHARED_BASE = 51;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

endpackage

// File: rtl/reg_file_ctx_if.sv
// Port bundle of the context-banked register file: 3-read/1-write datapath,
// context control and debug read. The core sits on the slave side.
interface reg_file_ctx_if #(
  parameter int DATA_WIDTH = reg_file_ctx_pkg::DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_file_ctx_pkg::DEF_ADDR_WIDTH,
  parameter int CTX_WIDTH  = reg_file_ctx_pkg::DEF_CTX_WIDTH
);

  logic                         Reg_Write;
  logic [ADDR_WIDTH-1:0]        Write_Reg;
  logic signed [DATA_WIDTH-1:0] Write_Data;
  logic [ADDR_WIDTH-1:0]        Read_Reg_1;
  logic [ADDR_WIDTH-1:0]        Read_Reg_2;
  logic [ADDR_WIDTH-1:0]        Read_Reg_3;
  logic signed [DATA_WIDTH-1:0] Data_1;
  logic signed [DATA_WIDTH-1:0] Data_2;
  logic signed [DATA_WIDTH-1:0] Data_3;
  logic [CTX_WIDTH-1:0]         Ctx_Sel;
  logic                         Ctx_Switch;
  logic                         Ctx_Clear;
  logic [CTX_WIDTH-1:0]         Active_Ctx;
  logic                         Busy;
  logic                         Clear_Done;
  logic [CTX_WIDTH-1:0]         Debug_Ctx;
  logic [ADDR_WIDTH-1:0]        Debug_Reg;
  logic [DATA_WIDTH-1:0]        Debug_Data;

  modport master (
    output Reg_Write, Write_Reg, Write_Data, Read_Reg_1, Read_Reg_2, Read_Reg_3,
    output Ctx_Sel, Ctx_Switch, Ctx_Clear, Debug_Ctx, Debug_Reg,
    input  Data_1, Data_2, Data_3, Active_Ctx, Busy, Clear_Done, Debug_Data
  );

  modport slave (
    input  Reg_Write, Write_Reg, Write_Data, Read_Reg_1, Read_Reg_2, Read_Reg_3,
    input  Ctx_Sel, Ctx_Switch, Ctx_Clear, Debug_Ctx, Debug_Reg,
    output Data_1, Data_2, Data_3, Active_Ctx, Busy, Clear_Done, Debug_Data
  );

endinterface

// File: rtl/reg_file_clear_fsm.sv
// Background clear engine: walks indices 1..SHARED_BASE-1 of one private bank,
// one index per cycle, then pulses clear_done_o.
module reg_file_clear_fsm
  import reg_file_ctx_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int CTX_WIDTH   = DEF_CTX_WIDTH,
  parameter int SHARED_BASE = DEF_SHARED_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req_i,
  input  logic [CTX_WIDTH-1:0]  ctx_sel_i,
  output logic                  busy_o,
  output logic                  clear_done_o,
  output logic                  clr_stb_o,
  output logic [ADDR_WIDTH-1:0] clr_idx_o,
  output logic [CTX_WIDTH-1:0]  clr_ctx_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SHARED_BASE - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [CTX_WIDTH-1:0]  ctx_q;
  logic                  busy_q;
  logic                  done_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
      ctx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          done_q <= 1'b0;
          if (clear_req_i) begin
            ctx_q   <= ctx_sel_i;
            ptr_q   <= PTR_ONE;
            busy_q  <= 1'b1;
            state_q <= CLR_RUN;
          end
        end
        CLR_RUN: begin
          ptr_q <= ptr_q + PTR_ONE;
          if (ptr_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= CLR_DONE;
          end
        end
        CLR_DONE: begin
          done_q  <= 1'b0;
          state_q <= CLR_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= CLR_IDLE;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign clear_done_o = done_q;
  assign clr_stb_o    = (state_q == CLR_RUN);
  assign clr_idx_o    = ptr_q;
  assign clr_ctx_o    = ctx_q;

endmodule

// File: rtl/reg_file_ctx.sv
// Context-banked register file: NUM_CTX private banks below SHARED_BASE, one
// global bank above it, combinational reads with write bypass, debug peek port.
module reg_file_ctx
  import reg_file_ctx_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_CTX     = DEF_NUM_CTX,
  parameter int CTX_WIDTH   = DEF_CTX_WIDTH,
  parameter int SHARED_BASE = DEF_SHARED_BASE
) (
  input logic           Clock,
  input logic           Reset,
  reg_file_ctx_if.slave bus
);

  localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] SHARED_IDX = ADDR_WIDTH'(SHARED_BASE);

  logic [DATA_WIDTH-1:0] priv_q [NUM_CTX][SHARED_BASE];
  logic [DATA_WIDTH-1:0] glob_q [SHARED_BASE:DEPTH-1];
  logic [CTX_WIDTH-1:0]  active_q;

  logic                  clr_stb;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [CTX_WIDTH-1:0]  clr_ctx;
  logic                  wr_en;
  logic                  wr_global;

  reg_file_clear_fsm #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .CTX_WIDTH   (CTX_WIDTH),
    .SHARED_BASE (SHARED_BASE)
  ) u_clear_fsm (
    .clk          (Clock),
    .rst          (Reset),
    .clear_req_i  (bus.Ctx_Clear),
    .ctx_sel_i    (bus.Ctx_Sel),
    .busy_o       (bus.Busy),
    .clear_done_o (bus.Clear_Done),
    .clr_stb_o    (clr_stb),
    .clr_idx_o    (clr_idx),
    .clr_ctx_o    (clr_ctx)
  );

  assign wr_en     = bus.Reg_Write && (bus.Write_Reg != '0);
  assign wr_global = (bus.Write_Reg >= SHARED_IDX);

  // NOTE: the storage array is reset on purpose: reset must zero every bank
  // asynchronously, which rules out mapping it onto a RAM macro.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      active_q <= '0;
      for (int c = 0; c < NUM_CTX; c++)
        for (int i = 0; i < SHARED_BASE; i++) priv_q[c][i] <= '0;
      for (int i = SHARED_BASE; i < DEPTH; i++) glob_q[i] <= '0;
    end else begin
      if (bus.Ctx_Switch) active_q <= bus.Ctx_Sel;
      // Clear first, write second: on a same-index collision the write wins.
      if (clr_stb) priv_q[clr_ctx][clr_idx] <= '0;
      if (wr_en) begin
        if (wr_global) glob_q[bus.Write_Reg] <= bus.Write_Data;
        else           priv_q[active_q][bus.Write_Reg] <= bus.Write_Data;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] stored_val(input logic [CTX_WIDTH-1:0]  ctx,
                                                       input logic [ADDR_WIDTH-1:0] idx);
    if (idx == '0)              return '0;
    else if (idx >= SHARED_IDX) return glob_q[idx];
    else                        return priv_q[ctx][idx];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    if (wr_en && (bus.Write_Reg == idx)) return bus.Write_Data;
    else                                 return stored_val(active_q, idx);
  endfunction

  assign bus.Data_1     = read_port(bus.Read_Reg_1);
  assign bus.Data_2     = read_port(bus.Read_Reg_2);
  assign bus.Data_3     = read_port(bus.Read_Reg_3);
  assign bus.Debug_Data = stored_val(bus.Debug_Ctx, bus.Debug_Reg);
  assign bus.Active_Ctx = active_q;

endmodule

// File: tb/tb_reg_file_ctx.sv
// Directed bench for reg_file_ctx: single-cycle vector table followed by clear
// engine and asynchronous-reset sequences.
module tb_reg_file_ctx;

  logic Clock;
  logic Reset;
  int   total;
  int   bad;

  reg_file_ctx_if bus ();

  reg_file_ctx dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic        we;
    logic [5:0]  wr;
    logic [31:0] wd;
    logic [5:0]  r1, r2, r3;
    logic [1:0]  sel;
    logic        sw;
    logic [1:0]  dctx;
    logic [5:0]  dreg;
    logic [31:0] e1, e2, e3;
    logic [1:0]  eact;
    logic [31:0] edbg;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.Reg_Write  = 1'b0;
    bus.Write_Reg  = '0;
    bus.Write_Data = '0;
    bus.Ctx_Switch = 1'b0;
    bus.Ctx_Clear  = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int errs;
    total = 0;
    bad   = 0;

    //          we    wr      wd            r1     r2     r3     sel   sw    dctx  dreg    e1            e2            e3            eact  edbg
    vecs[0]  = '{1'b0, 6'd0,  32'h0,        6'd5,  6'd0,  6'd60, 2'd0, 1'b0, 2'd0, 6'd5,  32'h0,        32'h0,        32'h0,        2'd0, 32'h0};
    vecs[1]  = '{1'b1, 6'd5,  32'hDEADBEEF, 6'd5,  6'd0,  6'd6,  2'd0, 1'b0, 2'd0, 6'd5,  32'hDEADBEEF, 32'h0,        32'h0,        2'd0, 32'h0};
    vecs[2]  = '{1'b1, 6'd0,  32'h7,        6'd0,  6'd5,  6'd0,  2'd0, 1'b0, 2'd0, 6'd5,  32'h0,        32'hDEADBEEF, 32'h0,        2'd0, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 6'd0,  32'h0,        6'd0,  6'd5,  6'd0,  2'd0, 1'b0, 2'd0, 6'd0,  32'h0,        32'hDEADBEEF, 32'h0,        2'd0, 32'h0};
    vecs[4]  = '{1'b1, 6'd5,  32'd11,       6'd5,  6'd5,  6'd0,  2'd0, 1'b0, 2'd0, 6'd5,  32'd11,       32'd11,       32'h0,        2'd0, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 6'd0,  32'h0,        6'd5,  6'd0,  6'd0,  2'd1, 1'b1, 2'd0, 6'd5,  32'd11,       32'h0,        32'h0,        2'd0, 32'd11};
    vecs[6]  = '{1'b1, 6'd5,  32'd22,       6'd5,  6'd0,  6'd0,  2'd0, 1'b0, 2'd0, 6'd5,  32'd22,       32'h0,        32'h0,        2'd1, 32'd11};
    vecs[7]  = '{1'b0, 6'd0,  32'h0,        6'd5,  6'd0,  6'd0,  2'd0, 1'b0, 2'd1, 6'd5,  32'd22,       32'h0,        32'h0,        2'd1, 32'd22};
    vecs[8]  = '{1'b0, 6'd0,  32'h0,        6'd5,  6'd0,  6'd0,  2'd2, 1'b1, 2'd1, 6'd5,  32'd22,       32'h0,        32'h0,        2'd1, 32'd22};
    vecs[9]  = '{1'b1, 6'd60, 32'hFFFFFFFF, 6'd60, 6'd5,  6'd0,  2'd0, 1'b0, 2'd2, 6'd60, 32'hFFFFFFFF, 32'h0,        32'h0,        2'd2, 32'h0};
    vecs[10] = '{1'b0, 6'd0,  32'h0,        6'd60, 6'd0,  6'd0,  2'd3, 1'b1, 2'd0, 6'd60, 32'hFFFFFFFF, 32'h0,        32'h0,        2'd2, 32'hFFFFFFFF};
    vecs[11] = '{1'b0, 6'd0,  32'h0,        6'd60, 6'd5,  6'd0,  2'd0, 1'b0, 2'd3, 6'd60, 32'hFFFFFFFF, 32'h0,        32'h0,        2'd3, 32'hFFFFFFFF};
    vecs[12] = '{1'b0, 6'd0,  32'h0,        6'd60, 6'd0,  6'd0,  2'd0, 1'b1, 2'd3, 6'd5,  32'hFFFFFFFF, 32'h0,        32'h0,        2'd3, 32'h0};
    vecs[13] = '{1'b1, 6'd7,  32'd9,        6'd7,  6'd60, 6'd0,  2'd1, 1'b1, 2'd0, 6'd7,  32'd9,        32'hFFFFFFFF, 32'h0,        2'd0, 32'h0};
    vecs[14] = '{1'b0, 6'd0,  32'h0,        6'd7,  6'd5,  6'd60, 2'd0, 1'b0, 2'd0, 6'd7,  32'h0,        32'd22,       32'hFFFFFFFF, 2'd1, 32'd9};
    vecs[15] = '{1'b0, 6'd0,  32'h0,        6'd5,  6'd63, 6'd51, 2'd0, 1'b0, 2'd1, 6'd7,  32'd22,       32'h0,        32'h0,        2'd1, 32'h0};

    Reset = 1'b1;
    idle_inputs();
    bus.Ctx_Sel    = '0;
    bus.Read_Reg_1 = '0;
    bus.Read_Reg_2 = '0;
    bus.Read_Reg_3 = '0;
    bus.Debug_Ctx  = '0;
    bus.Debug_Reg  = '0;
    #12;
    check("reset busy", {31'b0, bus.Busy}, 32'd0);
    check("reset done", {31'b0, bus.Clear_Done}, 32'd0);
    check("reset active", {30'b0, bus.Active_Ctx}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // Single-cycle vector table: drive at negedge, compare before the next posedge.
    for (int i = 0; i < 16; i++) begin
      @(negedge Clock);
      bus.Reg_Write  = vecs[i].we;
      bus.Write_Reg  = vecs[i].wr;
      bus.Write_Data = vecs[i].wd;
      bus.Read_Reg_1 = vecs[i].r1;
      bus.Read_Reg_2 = vecs[i].r2;
      bus.Read_Reg_3 = vecs[i].r3;
      bus.Ctx_Sel    = vecs[i].sel;
      bus.Ctx_Switch = vecs[i].sw;
      bus.Ctx_Clear  = 1'b0;
      bus.Debug_Ctx  = vecs[i].dctx;
      bus.Debug_Reg  = vecs[i].dreg;
      #2;
      check($sformatf("v%0d data1", i), bus.Data_1, vecs[i].e1);
      check($sformatf("v%0d data2", i), bus.Data_2, vecs[i].e2);
      check($sformatf("v%0d data3", i), bus.Data_3, vecs[i].e3);
      check($sformatf("v%0d active", i), {30'b0, bus.Active_Ctx}, {30'b0, vecs[i].eact});
      check($sformatf("v%0d debug", i), bus.Debug_Data, vecs[i].edbg);
    end

    // Fill ctx1 (active) r1..r50 with their own index.
    for (int r = 1; r <= 50; r++) begin
      @(negedge Clock);
      idle_inputs();
      bus.Reg_Write  = 1'b1;
      bus.Write_Reg  = 6'(r);
      bus.Write_Data = r;
    end
    @(negedge Clock);
    idle_inputs();
    bus.Debug_Ctx = 2'd1;
    bus.Debug_Reg = 6'd50;
    #2;
    check("fill ctx1 r50", bus.Debug_Data, 32'd50);

    // Clear ctx1 with mid-run writes and an ignored second request.
    @(negedge Clock);
    bus.Ctx_Sel   = 2'd1;
    bus.Ctx_Clear = 1'b1;
    #2;
    check("busy before clear edge", {31'b0, bus.Busy}, 32'd0);
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 1; c <= 53; c++) begin
      @(negedge Clock);
      idle_inputs();
      case (c)
        20: begin bus.Reg_Write = 1'b1; bus.Write_Reg = 6'd40; bus.Write_Data = 32'd5;    end
        21: begin bus.Reg_Write = 1'b1; bus.Write_Reg = 6'd10; bus.Write_Data = 32'd5;    end
        25: begin bus.Reg_Write = 1'b1; bus.Write_Reg = 6'd25; bus.Write_Data = 32'h77;   end
        30: begin bus.Ctx_Sel = 2'd2; bus.Ctx_Clear = 1'b1; end
        default: ;
      endcase
      #2;
      if (bus.Busy) busy_cnt++;
      if (bus.Clear_Done) done_cnt++;
      if (c == 1)  check("busy first cycle", {31'b0, bus.Busy}, 32'd1);
      if (c == 51) check("done after last", {31'b0, bus.Clear_Done}, 32'd1);
    end
    check("busy cycles", busy_cnt, 32'd50);
    check("done pulses", done_cnt, 32'd1);

    errs = 0;
    bus.Debug_Ctx = 2'd1;
    for (int r = 1; r <= 50; r++) begin
      bus.Debug_Reg = 6'(r);
      #1;
      if (bus.Debug_Data !== ((r == 10) ? 32'd5 : (r == 25) ? 32'h77 : 32'd0)) errs++;
    end
    check("ctx1 cleared regs", errs, 32'd0);
    bus.Debug_Ctx  = 2'd0;
    bus.Debug_Reg  = 6'd5;
    bus.Read_Reg_1 = 6'd60;
    #1;
    check("ctx0 r5 untouched", bus.Debug_Data, 32'd11);
    check("global r60 untouched", bus.Data_1, 32'hFFFFFFFF);

    // Simultaneous switch+clear to ctx3, then async reset at pointer 25.
    @(negedge Clock);
    idle_inputs();
    bus.Ctx_Sel    = 2'd3;
    bus.Ctx_Switch = 1'b1;
    bus.Ctx_Clear  = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge Clock);
      idle_inputs();
      #2;
      if (c == 1) begin
        check("switch+clear active", {30'b0, bus.Active_Ctx}, 32'd3);
        check("switch+clear busy", {31'b0, bus.Busy}, 32'd1);
      end
    end
    check("pre-reset ctx0 r5", bus.Debug_Data, 32'd11);
    check("pre-reset r60", bus.Data_1, 32'hFFFFFFFF);
    Reset = 1'b1;
    #1;
    check("async reset busy", {31'b0, bus.Busy}, 32'd0);
    check("async reset active", {30'b0, bus.Active_Ctx}, 32'd0);
    check("async reset ctx0 r5", bus.Debug_Data, 32'd0);
    check("async reset r60", bus.Data_1, 32'd0);
    errs = 0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 64; r++) begin
        bus.Debug_Ctx = 2'(c);
        bus.Debug_Reg = 6'(r);
        #1;
        if (bus.Debug_Data !== 32'd0) errs++;
      end
    end
    check("async reset all zero", errs, 32'd0);

    @(negedge Clock);
    Reset    = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock);
      #2;
      if (bus.Busy) busy_cnt++;
    end
    check("clear aborted by reset", busy_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
